// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle logic/arith/compare ops, iterative 1-bit-per-cycle shifts.
// Valid/ready on both sides; result and zero are registered and hold until consumed.
module alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] work, work_step, quick_res;
  logic [SHW-1:0]  cnt, amt;
  logic [1:0]      sh_op;
  logic            accept, is_shift, last_step;

  always_comb begin
    quick_res = '0;
    case (alu_sel)
      4'b0000: quick_res = op_a + op_b;
      4'b0001: quick_res = op_a - op_b;
      4'b0010: quick_res = op_a ^ op_b;
      4'b0011: quick_res = op_a | op_b;
      4'b0100: quick_res = op_a & op_b;
      4'b0101, 4'b0110, 4'b0111: quick_res = op_a;  // shift by 0 passes op_a through
      4'b1000: quick_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1001: quick_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default: quick_res = '0;
    endcase
  end

  always_comb begin
    amt       = op_b[SHW-1:0];
    is_shift  = (alu_sel == 4'b0101) || (alu_sel == 4'b0110) || (alu_sel == 4'b0111);
    accept    = in_valid && in_ready;
    last_step = (cnt == SHW'(1));
  end

  // sh_op holds alu_sel[1:0]: 01 = SLL, 10 = SRL, 11 = SRA
  always_comb begin
    work_step = work;
    case (sh_op)
      2'b01:   work_step = {work[XLEN-2:0], 1'b0};
      2'b10:   work_step = {1'b0, work[XLEN-1:1]};
      default: work_step = {work[XLEN-1], work[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (is_shift && amt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      sh_op  <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && amt != '0) begin
              work  <= op_a;
              cnt   <= amt;
              sh_op <= alu_sel[1:0];
            end else begin
              result <= quick_res;
              zero   <= (quick_res == '0);
            end
          end
        end
        SHIFT: begin
          work <= work_step;
          cnt  <= cnt - 1'b1;
          if (last_step) begin
            result <= work_step;
            zero   <= (work_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
